// File: rtl/sdram_arbiter.sv
// Four-port SDRAM arbiter/sequencer: port 0 fixed priority, ports 1-3 round-robin.
// Grants the controller's single read/write port, counts burst words and steers data.
module sdram_arbiter #(
  parameter int unsigned BURST_W = 10,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sdram_init_done,
  input  logic [3:0]             m_req,
  input  logic [3:0]             m_we,
  input  logic [95:0]            m_addr,
  input  logic [4*BURST_W-1:0]   m_burst,
  input  logic [63:0]            m_wdata,
  output logic [3:0]             m_grant,
  output logic [3:0]             m_wnext,
  output logic [3:0]             m_rvalid,
  output logic [15:0]            m_rdata,
  output logic [3:0]             m_done,
  output logic [3:0]             m_err,
  output logic                   sdram_wr_req,
  output logic                   sdram_rd_req,
  input  logic                   sdram_wr_ack,
  input  logic                   sdram_rd_ack,
  output logic [23:0]            sdram_wr_addr,
  output logic [23:0]            sdram_rd_addr,
  output logic [BURST_W-1:0]     sdram_wr_burst,
  output logic [BURST_W-1:0]     sdram_rd_burst,
  output logic [15:0]            sdram_din,
  input  logic [15:0]            sdram_dout
);

  localparam int unsigned CNT_W = BURST_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [3:0]         grant_q, grant_d;
  logic [1:0]         g_q, g_d;
  logic               we_q, we_d;
  logic [1:0]         rr_q, rr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic [23:0]        wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [BURST_W-1:0] wr_burst_q, wr_burst_d, rd_burst_q, rd_burst_d;
  logic [3:0]         rvalid_q, rvalid_d, done_q, done_d, err_q, err_d;
  logic [15:0]        rdata_q, rdata_d;

  logic               found;
  logic [1:0]         win, cand, rr_next;
  logic [2:0]         sum;
  logic [23:0]        addr_sel;
  logic [BURST_W-1:0] burst_sel, burst_clamp;
  logic               active, ack;

  // Winner selection: port 0 first, then ports 1-3 starting at the round-robin pointer
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;
    sum   = 3'd0;
    if (m_req[0]) begin
      found = 1'b1;
      win   = 2'd0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        sum  = {1'b0, rr_q} + 3'(k);
        cand = (sum > 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        if (!found && m_req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  assign addr_sel    = m_addr[24*int'(win) +: 24];
  assign burst_sel   = m_burst[BURST_W*int'(win) +: BURST_W];
  assign burst_clamp = (burst_sel == '0) ? BURST_W'(1) : burst_sel;
  assign rr_next     = (g_q == 2'd3) ? 2'd1 : g_q + 2'd1;

  // Acks only count while a transaction owns the controller port
  assign active = (state_q == S_ISSUE) || (state_q == S_DATA);
  assign ack    = active && (we_q ? sdram_wr_ack : sdram_rd_ack);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    g_d        = g_q;
    we_d       = we_q;
    rr_d       = rr_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    burst_d    = burst_q;
    wr_req_d   = wr_req_q;
    rd_req_d   = rd_req_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_burst_d = wr_burst_q;
    rd_burst_d = rd_burst_q;
    rvalid_d   = '0;
    rdata_d    = rdata_q;
    done_d     = '0;
    err_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (sdram_init_done && found) begin
          grant_d = 4'b0001 << win;
          g_d     = win;
          we_d    = m_we[win];
          cnt_d   = '0;
          tmo_d   = '0;
          burst_d = burst_clamp;
          if (m_we[win]) begin
            wr_addr_d  = addr_sel;
            wr_burst_d = burst_clamp;
          end else begin
            rd_addr_d  = addr_sel;
            rd_burst_d = burst_clamp;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE, S_DATA: begin
        if (state_q == S_ISSUE) begin
          wr_req_d = we_q;
          rd_req_d = !we_q;
        end
        if (ack) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!we_q) begin
            rvalid_d = grant_q;
            rdata_d  = sdram_dout;
          end
          if (cnt_d == {1'b0, burst_q}) begin
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
            done_d   = grant_q;
            state_d  = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end else if (state_q == S_ISSUE) begin
          // Controller never answered: abandon the transaction and report it
          if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
            err_d    = grant_q;
            grant_d  = '0;
            if (g_q != 2'd0) rr_d = rr_next;
            state_d  = S_IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
      S_DONE: begin
        grant_d = '0;
        if (g_q != 2'd0) rr_d = rr_next;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      g_q        <= '0;
      we_q       <= 1'b0;
      rr_q       <= 2'd1;
      tmo_q      <= '0;
      cnt_q      <= '0;
      burst_q    <= '0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_burst_q <= '0;
      rd_burst_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      g_q        <= g_d;
      we_q       <= we_d;
      rr_q       <= rr_d;
      tmo_q      <= tmo_d;
      cnt_q      <= cnt_d;
      burst_q    <= burst_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_burst_q <= wr_burst_d;
      rd_burst_q <= rd_burst_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign m_grant        = grant_q;
  assign m_rvalid       = rvalid_q;
  assign m_rdata        = rdata_q;
  assign m_done         = done_q;
  assign m_err          = err_q;
  assign sdram_wr_req   = wr_req_q;
  assign sdram_rd_req   = rd_req_q;
  assign sdram_wr_addr  = wr_addr_q;
  assign sdram_rd_addr  = rd_addr_q;
  assign sdram_wr_burst = wr_burst_q;
  assign sdram_rd_burst = rd_burst_q;

  // Write data and word-consumed strobe pass straight through from the granted port
  assign sdram_din = (active && we_q) ? m_wdata[16*int'(g_q) +: 16] : 16'h0000;
  assign m_wnext   = (active && we_q && sdram_wr_ack) ? grant_q : 4'b0000;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: read, write, priority/round-robin, gating,
// timeout, and reset with burst clamp.
module tb_sdram_arbiter;

  localparam int BURST_W = 10;
  localparam int TIMEOUT = 1023;

  logic                 clk;
  logic                 rst_n;
  logic                 sdram_init_done;
  logic [3:0]           m_req, m_we;
  logic [95:0]          m_addr;
  logic [4*BURST_W-1:0] m_burst;
  logic [63:0]          m_wdata;
  logic [3:0]           m_grant, m_wnext, m_rvalid, m_done, m_err;
  logic [15:0]          m_rdata;
  logic                 sdram_wr_req, sdram_rd_req, sdram_wr_ack, sdram_rd_ack;
  logic [23:0]          sdram_wr_addr, sdram_rd_addr;
  logic [BURST_W-1:0]   sdram_wr_burst, sdram_rd_burst;
  logic [15:0]          sdram_din, sdram_dout;

  int nvec = 0;
  int nerr = 0;

  sdram_arbiter #(.BURST_W(BURST_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_burst(m_burst), .m_wdata(m_wdata),
    .m_grant(m_grant), .m_wnext(m_wnext), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .m_done(m_done), .m_err(m_err),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
    .sdram_wr_burst(sdram_wr_burst), .sdram_rd_burst(sdram_rd_burst),
    .sdram_din(sdram_din), .sdram_dout(sdram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller stand-in: acks every cycle its request is high
  task automatic tick_auto();
    @(posedge clk); #1;
    sdram_wr_ack = sdram_wr_req;
    sdram_rd_ack = sdram_rd_req;
    sdram_dout   = sdram_dout + 16'd1;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m_req = 4'b0000;
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sdram_init_done = 1'b0;
    m_req = 4'b0000; m_we = 4'b0000; m_addr = '0; m_burst = '0; m_wdata = '0;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_dout = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({m_grant, m_wnext, m_rvalid, m_done, m_err} !== 20'h0) begin
      nerr++; $display("FAIL reset_strobes: got %h expected 0", {m_grant, m_wnext, m_rvalid, m_done, m_err});
    end
    nvec++;
    if ({sdram_wr_req, sdram_rd_req, m_rdata, sdram_din} !== 34'h0) begin
      nerr++; $display("FAIL reset_req_data: got %h expected 0", {sdram_wr_req, sdram_rd_req, m_rdata, sdram_din});
    end
    nvec++;
    if ({sdram_wr_addr, sdram_rd_addr, sdram_wr_burst, sdram_rd_burst} !== 68'h0) begin
      nerr++; $display("FAIL reset_addr_burst: got %h expected 0",
                       {sdram_wr_addr, sdram_rd_addr, sdram_wr_burst, sdram_rd_burst});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_gating();
    int bad = 0;
    m_burst = {4{10'd1}};
    m_we = 4'b0000;
    m_req = 4'b1111;
    for (int c = 0; c < 50; c++) begin
      tick_auto();
      if (m_grant !== 4'b0000 || sdram_wr_req !== 1'b0 || sdram_rd_req !== 1'b0) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL gating_no_grant: got %0d active cycles expected 0", bad);
    end
    sdram_init_done = 1'b1;
    tick_auto();
    nvec++;
    if (m_grant !== 4'b0001) begin
      nerr++; $display("FAIL gating_release_grant: got %b expected 0001", m_grant);
    end
    m_req = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      tick_auto();
      if (m_done !== 4'b0000) break;
    end
    nvec++;
    if (m_done !== 4'b0001) begin
      nerr++; $display("FAIL gating_done: got %b expected 0001", m_done);
    end
    tick_auto();
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
  endtask

  task automatic test_single_read();
    m_addr[24 +: 24]    = 24'h000100;
    m_burst[10 +: 10]   = 10'd4;
    m_we                = 4'b0000;
    m_req               = 4'b0010;
    @(posedge clk); #1;
    nvec++;
    if (m_grant !== 4'b0010 || sdram_rd_req !== 1'b0) begin
      nerr++; $display("FAIL read_grant: got grant %b rd_req %b expected 0010 0", m_grant, sdram_rd_req);
    end
    nvec++;
    if (sdram_rd_addr !== 24'h000100 || sdram_rd_burst !== 10'd4) begin
      nerr++; $display("FAIL read_latch: got %h/%0d expected 000100/4", sdram_rd_addr, sdram_rd_burst);
    end
    @(posedge clk); #1;
    nvec++;
    if (sdram_rd_req !== 1'b1 || sdram_wr_req !== 1'b0) begin
      nerr++; $display("FAIL read_req: got rd %b wr %b expected 1 0", sdram_rd_req, sdram_wr_req);
    end
    m_req = 4'b0000;
    sdram_rd_ack = 1'b1;
    sdram_dout = 16'h00A0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      nvec++;
      if (m_rvalid !== 4'b0010 || m_rdata !== 16'(16'h00A0 + k)) begin
        nerr++; $display("FAIL read_word[%0d]: got rvalid %b data %h expected 0010 %h",
                         k, m_rvalid, m_rdata, 16'(16'h00A0 + k));
      end
      nvec++;
      if (m_done !== ((k == 3) ? 4'b0010 : 4'b0000)) begin
        nerr++; $display("FAIL read_done[%0d]: got %b", k, m_done);
      end
      if (k < 3) sdram_dout = 16'(16'h00A1 + k);
      else sdram_rd_ack = 1'b0;
    end
    nvec++;
    if (sdram_rd_req !== 1'b0) begin
      nerr++; $display("FAIL read_req_drop: got %b expected 0", sdram_rd_req);
    end
    // A stray ack while idle must not produce a strobe
    sdram_rd_ack = 1'b1;
    @(posedge clk); #1;
    sdram_rd_ack = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (m_rvalid !== 4'b0000 || m_grant !== 4'b0000 || m_done !== 4'b0000) begin
      nerr++; $display("FAIL read_idle_ack: got rvalid %b grant %b done %b expected 0", m_rvalid, m_grant, m_done);
    end
  endtask

  task automatic test_write_burst();
    int nw = 0;
    m_addr[48 +: 24]  = 24'h123456;
    m_burst[20 +: 10] = 10'd16;
    m_we              = 4'b0100;
    m_wdata[32 +: 16] = 16'h1000;
    m_req             = 4'b0100;
    @(posedge clk); #1;
    nvec++;
    if (m_grant !== 4'b0100 || sdram_wr_burst !== 10'd16 || sdram_wr_addr !== 24'h123456) begin
      nerr++; $display("FAIL write_grant: got %b burst %0d addr %h expected 0100 16 123456",
                       m_grant, sdram_wr_burst, sdram_wr_addr);
    end
    @(posedge clk); #1;
    nvec++;
    if (sdram_wr_req !== 1'b1 || sdram_rd_req !== 1'b0) begin
      nerr++; $display("FAIL write_req: got wr %b rd %b expected 1 0", sdram_wr_req, sdram_rd_req);
    end
    m_req = 4'b0000;
    for (int k = 0; k < 16; k++) begin
      if (k == 6) begin
        sdram_wr_ack = 1'b0;
        #1;
        nvec++;
        if (m_wnext !== 4'b0000) begin
          nerr++; $display("FAIL write_gap_wnext: got %b expected 0000", m_wnext);
        end
        @(posedge clk); #1;
      end
      sdram_wr_ack = 1'b1;
      #1;
      nvec++;
      if (sdram_din !== 16'(16'h1000 + k)) begin
        nerr++; $display("FAIL write_din[%0d]: got %h expected %h", k, sdram_din, 16'(16'h1000 + k));
      end
      if (m_wnext === 4'b0100) nw++;
      @(posedge clk); #1;
      m_wdata[32 +: 16] = 16'(16'h1001 + k);
    end
    sdram_wr_ack = 1'b0;
    #1;
    nvec++;
    if (nw != 16) begin
      nerr++; $display("FAIL write_wnext_count: got %0d expected 16", nw);
    end
    nvec++;
    if (m_done !== 4'b0100 || sdram_wr_req !== 1'b0) begin
      nerr++; $display("FAIL write_done: got done %b wr_req %b expected 0100 0", m_done, sdram_wr_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_priority_rr();
    logic [3:0] ord [5];
    logic [3:0] exp_ord [5];
    logic [3:0] prev = 4'b0000;
    logic       done1 = 1'b0;
    logic       p1_first = 1'b0;
    int         n = 0;
    exp_ord = '{4'b0010, 4'b0001, 4'b0100, 4'b1000, 4'b0010};
    for (int i = 0; i < 5; i++) ord[i] = 4'b0000;
    apply_reset();
    m_burst = {4{10'd2}};
    m_we = 4'b0000;
    m_req = 4'b1110;
    for (int c = 0; c < 300 && n < 5; c++) begin
      tick_auto();
      if (m_done[1] === 1'b1 && n == 1) done1 = 1'b1;
      if (m_grant !== 4'b0000 && prev === 4'b0000) begin
        ord[n] = m_grant;
        n++;
        if (n == 1 && m_grant === 4'b0010) m_req[0] = 1'b1;
        if (m_grant === 4'b0001) begin
          m_req[0] = 1'b0;
          p1_first = done1;
        end
      end
      prev = m_grant;
    end
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (ord[i] !== exp_ord[i]) begin
        nerr++; $display("FAIL rr_order[%0d]: got %b expected %b", i, ord[i], exp_ord[i]);
      end
    end
    nvec++;
    if (p1_first !== 1'b1) begin
      nerr++; $display("FAIL rr_no_preempt: got %b expected 1", p1_first);
    end
    m_req = 4'b0000;
    for (int c = 0; c < 50; c++) begin
      tick_auto();
      if (m_grant === 4'b0000) break;
    end
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int k = 0;
    int nrv = 0;
    m_we = 4'b0000;
    m_burst[30 +: 10] = 10'd3;
    m_req = 4'b1000;
    @(posedge clk); #1;
    nvec++;
    if (m_grant !== 4'b1000) begin
      nerr++; $display("FAIL tmo_grant: got %b expected 1000", m_grant);
    end
    m_req = 4'b0000;
    for (int c = 0; c < TIMEOUT + 20; c++) begin
      @(posedge clk); #1;
      k++;
      if (m_err !== 4'b0000) break;
    end
    nvec++;
    if (k != TIMEOUT) begin
      nerr++; $display("FAIL tmo_latency: got %0d cycles expected %0d", k, TIMEOUT);
    end
    nvec++;
    if (m_err !== 4'b1000 || sdram_rd_req !== 1'b0 || m_done !== 4'b0000) begin
      nerr++; $display("FAIL tmo_err: got err %b rd_req %b done %b expected 1000 0 0", m_err, sdram_rd_req, m_done);
    end
    @(posedge clk); #1;
    nvec++;
    if (m_err !== 4'b0000) begin
      nerr++; $display("FAIL tmo_err_pulse: got %b expected 0000", m_err);
    end
    m_req = 4'b1000;
    for (int c = 0; c < 50; c++) begin
      tick_auto();
      if (m_grant !== 4'b0000) m_req = 4'b0000;
      if (m_rvalid === 4'b1000) nrv++;
      if (m_done !== 4'b0000) break;
    end
    nvec++;
    if (m_done !== 4'b1000 || nrv != 3) begin
      nerr++; $display("FAIL tmo_retry: got done %b rvalid %0d expected 1000 3", m_done, nrv);
    end
    tick_auto();
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
  endtask

  task automatic test_reset_clamp();
    int nack = 0;
    int nw = 0;
    logic granted = 1'b0;
    m_we = 4'b0010;
    m_burst[10 +: 10] = 10'd16;
    m_addr[24 +: 24] = 24'h00ABCD;
    m_req = 4'b0010;
    for (int c = 0; c < 60; c++) begin
      tick_auto();
      if (m_grant !== 4'b0000) m_req = 4'b0000;
      if (sdram_wr_ack === 1'b1) nack++;
      if (nack == 5) break;
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({m_grant, m_wnext, m_rvalid, m_done, m_err, sdram_wr_req, sdram_rd_req} !== 22'h0) begin
      nerr++; $display("FAIL rst_mid_strobes: got %h expected 0",
                       {m_grant, m_wnext, m_rvalid, m_done, m_err, sdram_wr_req, sdram_rd_req});
    end
    nvec++;
    if ({m_rdata, sdram_din, sdram_wr_addr, sdram_rd_addr, sdram_wr_burst, sdram_rd_burst} !== 100'h0) begin
      nerr++; $display("FAIL rst_mid_data: got %h expected 0",
                       {m_rdata, sdram_din, sdram_wr_addr, sdram_rd_addr, sdram_wr_burst, sdram_rd_burst});
    end
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_burst[10 +: 10] = 10'd0;
    m_req = 4'b0010;
    for (int c = 0; c < 30; c++) begin
      tick_auto();
      if (m_wnext === 4'b0010) nw++;
      if (m_grant !== 4'b0000 && !granted) begin
        granted = 1'b1;
        m_req = 4'b0000;
        nvec++;
        if (sdram_wr_burst !== 10'd1) begin
          nerr++; $display("FAIL clamp_burst: got %0d expected 1", sdram_wr_burst);
        end
      end
      if (m_done !== 4'b0000) break;
    end
    nvec++;
    if (m_done !== 4'b0010 || nw != 1) begin
      nerr++; $display("FAIL clamp_words: got done %b wnext %0d expected 0010 1", m_done, nw);
    end
    tick_auto();
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_gating();
    test_single_read();
    test_write_burst();
    test_priority_rr();
    test_timeout();
    test_reset_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
